// File: rtl/direct_mapped_dcache.sv
// Direct-mapped write-through data cache with multi-word line refill.
// Define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
module direct_mapped_dcache #(
   parameter int NUM_SET         = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        Stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int W  = $clog2(WORDS_PER_BLOCK);
   localparam int S  = $clog2(NUM_SET);
   localparam int TW = 30 - W - S;
   localparam int CW = (W > 0) ? W : 1;

   typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wr_done_q, wr_done_d;
   logic [NUM_SET-1:0] valid_q;
   logic [TW-1:0]   tag_q  [NUM_SET];
   logic [31:0]     data_q [NUM_SET][WORDS_PER_BLOCK];

   logic [S-1:0]    set_idx;
   logic [TW-1:0]   tag_in;
   logic [CW-1:0]   word_idx;
   logic [31:0]     refill_addr;
   logic            hit, rd_req, wr_req, last;
   logic            fill_start, fill_word, fill_done, wr_upd;

   assign set_idx  = S'(ALUResultM >> (2 + W));
   assign tag_in   = TW'(ALUResultM >> (2 + W + S));
   assign word_idx = CW'(ALUResultM >> 2) & CW'(WORDS_PER_BLOCK - 1);
   assign refill_addr = (ALUResultM & ~32'(WORDS_PER_BLOCK * 4 - 1))
                      | (32'(cnt_q) << 2);

   assign hit    = valid_q[set_idx] && (tag_q[set_idx] == tag_in);
   assign rd_req = MemReadM && !MemWriteM;
   // A store already written through is not reissued while the
   // pipeline releases it.
   assign wr_req = MemWriteM && !wr_done_q;
   assign last   = (cnt_q == CW'(WORDS_PER_BLOCK - 1));

   assign fill_start = (state_q == IDLE) && (state_d == REFILL);
   assign fill_word  = (state_q == REFILL) && mem_ack;
   assign fill_done  = fill_word && last;
   assign wr_upd     = (state_q == WRITE) && mem_ack && hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_done_q <= wr_done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_req) begin
               state_d = WRITE;
            end else if (rd_req && !hit) begin
               state_d = REFILL;
               cnt_d   = '0;
            end
         end
         REFILL: begin
            if (mem_ack) begin
               cnt_d = cnt_q + 1'b1;
               if (last) state_d = IDLE;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               state_d   = IDLE;
               wr_done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Stall     = 1'b0;
      ReadDataM = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               Stall = wr_req || (rd_req && !hit);
               if (rd_req && hit) ReadDataM = data_q[set_idx][word_idx];
            end
            REFILL: begin
               Stall    = 1'b1;
               mem_req  = 1'b1;
               mem_addr = refill_addr;
            end
            WRITE: begin
               Stall     = 1'b1;
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = {ALUResultM[31:2], 2'b00};
               mem_wdata = WriteDataM;
            end
            default: Stall = 1'b0;
         endcase
      end
   end

   // Line stays invalid from the first refill word until the last.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (fill_start) begin
         valid_q[set_idx] <= 1'b0;
      end else if (fill_done) begin
         valid_q[set_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_word) data_q[set_idx][cnt_q] <= mem_rdata;
      if (fill_done) tag_q[set_idx] <= tag_in;
      if (wr_upd) data_q[set_idx][word_idx] <= WriteDataM;
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q, miss_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (state_q == IDLE && rd_req && hit) hit_q <= hit_q + 1'b1;
         if (fill_start) miss_q <= miss_q + 1'b1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_direct_mapped_dcache.sv
// Bench for direct_mapped_dcache: directed scenarios then random traffic
// against a set/tag model and a flat word memory.
module tb_direct_mapped_dcache;

   localparam int NS  = 8;
   localparam int WPB = 4;

   logic        clk, rst;
   logic        MemReadM, MemWriteM;
   logic [31:0] ALUResultM, WriteDataM, ReadDataM;
   logic        Stall, mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   direct_mapped_dcache #(.NUM_SET(NS), .WORDS_PER_BLOCK(WPB)) dut (
      .clk(clk), .rst(rst),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .Stall(Stall),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        log_q[$];
   logic [31:0] mem     [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic        m_valid [NS];
   int          m_tag   [NS];
   int          checks = 0, errors = 0;
   int          m_hits = 0, m_misses = 0;
   int          ack_dly = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory model: acks after ack_dly wait cycles, logs each transaction.
   initial begin : responder
      int wcnt;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (rst) begin
            wcnt = 0;
         end else if (mem_req) begin
            if (wcnt >= ack_dly) begin
               mem_ack = 1'b1;
               wcnt = 0;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else mem_rdata = rd_mem(mem_addr);
               log_q.push_back('{mem_we, mem_addr, mem_wdata});
            end else begin
               wcnt++;
            end
         end
      end
   end

   function automatic int set_of(input logic [31:0] a);
      return int'((a / (4 * WPB)) % NS);
   endfunction

   function automatic int tag_of(input logic [31:0] a);
      return int'(a / (4 * WPB * NS));
   endfunction

   task automatic wait_free(input string tag);
      int n;
      n = 0;
      while (Stall && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(Stall), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] addr);
      int s, t;
      logic exp_hit;
      logic [31:0] base;
      s = set_of(addr);
      t = tag_of(addr);
      base = addr & ~32'(WPB * 4 - 1);
      exp_hit = m_valid[s] && m_tag[s] == t;
      @(negedge clk);
      MemReadM = 1'b1;
      MemWriteM = 1'b0;
      ALUResultM = addr;
      log_q.delete();
      #1;
      chk("rd_stall", 32'(Stall), 32'(!exp_hit));
      if (!exp_hit) begin
         wait_free("rd_timeout");
         chk("rd_nreq", 32'(log_q.size()), 32'(WPB));
         foreach (log_q[i]) begin
            chk("rd_addr", log_q[i].addr, base + 32'(4 * i));
            chk("rd_we", 32'(log_q[i].we), 32'd0);
         end
         m_valid[s] = 1'b1;
         m_tag[s] = t;
         m_misses++;
      end else begin
         chk("rd_noreq", 32'(mem_req), 32'd0);
      end
      chk("rd_data", ReadDataM, rd_ref(addr & ~32'd3));
      m_hits++;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic both);
      @(negedge clk);
      MemReadM = both;
      MemWriteM = 1'b1;
      ALUResultM = addr;
      WriteDataM = data;
      log_q.delete();
      #1;
      chk("wr_stall", 32'(Stall), 32'd1);
      wait_free("wr_timeout");
      chk("wr_nreq", 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
         chk("wr_we", 32'(log_q[0].we), 32'd1);
         chk("wr_addr", log_q[0].addr, addr & ~32'd3);
         chk("wr_data", log_q[0].data, data);
      end
      ref_mem[addr & ~32'd3] = data;
   endtask

   task automatic do_idle();
      @(negedge clk);
      MemReadM = 1'b0;
      MemWriteM = 1'b0;
      ALUResultM = $urandom;
      #1;
      chk("idle_rdata", ReadDataM, 32'd0);
      chk("idle_stall", 32'(Stall), 32'd0);
      chk("idle_req", 32'(mem_req), 32'd0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n;
      rst = 1'b1;
      MemReadM = 1'b0;
      MemWriteM = 1'b0;
      ALUResultM = '0;
      WriteDataM = '0;
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", 32'(Stall), 32'd0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", ReadDataM, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
         ref_mem[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
      end
      ack_dly = 2;
      do_read(32'h40);
      chk("fill_word0", ReadDataM, 32'hA0);
      do_read(32'h48);
      chk("hit_word2", ReadDataM, 32'hA2);
      do_write(32'h44, 32'hDEAD_BEEF, 1'b0);
      do_read(32'h44);
      chk("wr_hit_upd", ReadDataM, 32'hDEAD_BEEF);
      do_idle();
      ack_dly = 1;
      do_write(32'h200, 32'h1234, 1'b0);
      do_read(32'h200);
      chk("no_alloc", 32'(m_misses), 32'd2);
      do_read(32'h140);
      do_read(32'h40);
      chk("conflict", 32'(m_misses), 32'd4);
      do_write(32'h4C, 32'h5555_AAAA, 1'b1);
      do_read(32'h4C);

      // Reset while the third word of a refill is outstanding.
      ack_dly = 2;
      @(negedge clk);
      MemReadM = 1'b1;
      MemWriteM = 1'b0;
      ALUResultM = 32'h300;
      log_q.delete();
      n = 0;
      while (log_q.size() < 2 && n < 100) begin
         @(posedge clk);
         #3;
         n++;
      end
      @(posedge clk);
      #3;
      chk("mid_req", 32'(mem_req), 32'd1);
      chk("mid_addr", mem_addr, 32'h308);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(mem_req), 32'd0);
      chk("arst_stall", 32'(Stall), 32'd0);
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_hits = 0;
      m_misses = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      MemReadM = 1'b0;
      do_read(32'h308);
      do_read(32'h40);

      for (int k = 0; k < 150; k++) begin
         int op;
         logic [31:0] a;
         ack_dly = $urandom_range(0, 3);
         a = $urandom_range(0, NS * WPB * 4 * 4 - 1);
         op = $urandom_range(0, 9);
         if (op < 6) do_read(a);
         else if (op < 9) do_write(a, $urandom, op == 8);
         else do_idle();
      end
      do_idle();

`ifdef DCACHE_STATS_EN
      chk("hit_count", hit_count, 32'(m_hits));
      chk("miss_count", miss_count, 32'(m_misses));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/direct_mapped_dcache.md
# direct_mapped_dcache

Parametrised direct-mapped data cache between the MEM stage and data memory. It generalises the single-word, write-only-fill cache to multi-word lines. Read misses are handled by a line-refill state machine over a request/acknowledge memory port. Writes are write-through, no-write-allocate, and the pipeline is stalled for the duration of any memory transaction.

## Interface
Parameters:
- NUM_SET, 8: number of lines; power of two, ≥2.
- WORDS_PER_BLOCK, 4: 32-bit words per line; power of two, ≥1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load request
- MemWriteM  in  1  store request; wins if both asserted
- ALUResultM  in  32  byte address; bits[1:0] ignored (word access only)
- WriteDataM  in  32  store data
- ReadDataM  out  32  load data
- Stall  out  1  freeze pipeline; request inputs held stable while high
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completes current request this cycle
- mem_rdata  in  32  read data, valid when mem_ack=1

## Operation
Address split, LSB first:
- 2 byte-offset bits.
- W = log2(WORDS_PER_BLOCK) word bits.
- S = log2(NUM_SET) set bits.
- Tag = remaining 30-W-S bits.

Storage per set: a valid bit, a tag, and WORDS_PER_BLOCK data words. There is no dirty bit.

FSM states:
- IDLE
  - Read hit: ReadDataM = line word, Stall=0.
  - Read miss: Stall=1; on the clock edge, go to REFILL with refill counter = 0.
  - Write (hit or miss): Stall=1; on the clock edge, go to WRITE.
  - No request: ReadDataM = 0.
- REFILL
  - mem_req=1, mem_we=0, mem_addr = {Tag, Set, counter, 2'b00}.
  - On mem_ack, store mem_rdata into word[counter] and increment the counter.
  - On the ack of the last word, set valid and write the tag, then return to IDLE.
  - The load then hits in IDLE next cycle with Stall=0.
  - Refill always starts at word 0; there is no critical-word-first.
- WRITE
  - mem_req=1, mem_we=1, mem_addr = {ALUResultM[31:2], 2'b00}, mem_wdata = WriteDataM.
  - On mem_ack: if the line is valid with a matching tag, update that word; else the cache is unchanged (no allocate). Return to IDLE.
  - The store is then complete; Stall=0 in the IDLE cycle that follows.
- Stall is 1 in REFILL and WRITE, and combinationally 1 in IDLE on a miss or write.

## Timing
- Reset values: state=IDLE, all valid=0, refill counter=0, Stall=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0. Tag/data arrays are not reset.
- Read-hit latency: 0 cycles (combinational).
- Read-miss penalty: 1 + Σ(ack wait cycles for WORDS_PER_BLOCK requests).
- Write penalty: 1 + ack wait.
- Handshake: mem_req/mem_we/mem_addr/mem_wdata are stable from assertion until the cycle mem_ack=1. In REFILL, the next word's request follows in the cycle after an ack. mem_ack while mem_req=0 is ignored.
- Reset mid-REFILL or mid-WRITE: the FSM returns to IDLE immediately (async), mem_req drops, and all lines are invalidated. A partially filled line is never marked valid.
- Conflict miss: refill overwrites the resident line; the valid bit stays 0 until the final word arrives.
- Write to the set being refilled cannot occur, because the pipeline is stalled.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count, miss_count (32 bits each, reset 0, wrap at 2^32-1 to 0).
  - hit_count increments once per read serviced without stall.
  - miss_count increments once per REFILL entry.
  - Writes are counted in neither.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then read 0x0000_0040 with mem_ack after 2 cycles per word, mem_rdata = 0xA0..0xA3: 4 read requests at 0x40,0x44,0x48,0x4C; then Stall=0 and ReadDataM=0xA0. Reading 0x48 next is a hit: 0xA2, no mem_req.
- After filling line 0x40, write 0xDEADBEEF to 0x44: one mem_we request at 0x44. A following read of 0x44 returns 0xDEADBEEF with no stall.
- Write 0x1234 to uncached 0x200: memory write issued. A following read of 0x200 misses and refills (no allocate).
- Conflict (defaults NUM_SET=8, WORDS_PER_BLOCK=4): fill 0x40, then read 0x140 (same set, different tag) → refill. A read of 0x40 misses again.
- Assert rst during the 3rd refill word: mem_req=0 and Stall=0 immediately. A subsequent read of the same address refills from word 0.
- DCACHE_STATS_EN: 3 hits + 2 misses → hit_count=3, miss_count=2. Preload 0xFFFF_FFFF and hit once → 0.
